// File: rtl/rom_sequencer.sv
// Address sequencer and output stage feeding a registered-output ROM.
// Walks first_addr..last_addr (modulo 2**ADDR_W) and presents each returned
// word over valid/ready, with optional per-entry hold and range looping.
module rom_sequencer #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned HOLD_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   input  logic [HOLD_W-1:0] hold_cycles,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_PRESENT,
      S_HOLD
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   dout_d;
   logic                valid_d;
   logic                done_d;
   logic [HOLD_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]   first_q, first_d;
   logic [ADDR_W-1:0]   last_q, last_d;
   logic                loop_q, loop_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                advance;

   // busy reflects the current state directly
   assign busy = (state_q != S_IDLE);

   // State, outputs and latched configuration registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rom_addr   <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         done       <= 1'b0;
         cnt_q      <= '0;
         first_q    <= '0;
         last_q     <= '0;
         loop_q     <= 1'b0;
         hold_q     <= '0;
      end else begin
         state_q    <= state_d;
         rom_addr   <= addr_d;
         data_out   <= dout_d;
         data_valid <= valid_d;
         done       <= done_d;
         cnt_q      <= cnt_d;
         first_q    <= first_d;
         last_q     <= last_d;
         loop_q     <= loop_d;
         hold_q     <= hold_d;
      end
   end

   // Next-state and next-output logic; stop overrides everything at the end
   always_comb begin
      state_d = state_q;
      addr_d  = rom_addr;
      dout_d  = data_out;
      valid_d = data_valid;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      first_d = first_q;
      last_d  = last_q;
      loop_d  = loop_q;
      hold_d  = hold_q;
      advance = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               first_d = first_addr;
               last_d  = last_addr;
               loop_d  = loop_en;
               hold_d  = hold_cycles;
               addr_d  = first_addr;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            dout_d  = rom_data;
            valid_d = 1'b1;
            state_d = S_PRESENT;
         end
         S_PRESENT: begin
            if (data_valid && data_ready) begin
               valid_d = 1'b0;
               if (hold_q == '0) begin
                  advance = 1'b1;
               end else begin
                  cnt_d   = hold_q;
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (cnt_q == HOLD_W'(1)) begin
               advance = 1'b1;
            end else begin
               cnt_d = cnt_q - HOLD_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Advance decision is folded into the exiting edge of PRESENT/HOLD
      if (advance) begin
         if (rom_addr != last_q) begin
            addr_d  = rom_addr + ADDR_W'(1);
            state_d = S_FETCH;
         end else if (loop_q) begin
            addr_d  = first_q;
            state_d = S_FETCH;
         end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
      end

      // Abort: back to IDLE, drop valid, keep address and data, no done
      if (stop) begin
         state_d = S_IDLE;
         addr_d  = rom_addr;
         dout_d  = data_out;
         valid_d = 1'b0;
         done_d  = 1'b0;
      end
   end

endmodule

// File: tb/tb_rom_sequencer.sv
// Directed bench for rom_sequencer with a registered-output ROM model and a
// scoreboard of expected (address, word) pairs checked at each handshake.
module tb_rom_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stop;
   logic        loop_en;
   logic [3:0]  first_addr;
   logic [3:0]  last_addr;
   logic [7:0]  hold_cycles;
   logic [3:0]  rom_addr;
   logic [15:0] rom_data;
   logic [15:0] data_out;
   logic        data_valid;
   logic        data_ready;
   logic        busy;
   logic        done;

   typedef struct {
      logic [3:0]  a;
      logic [15:0] d;
   } exp_t;

   exp_t        sb[$];
   int          acc_times[$];
   int          cyc;
   int          errors;
   int          checks;
   logic [15:0] rom [16];

   rom_sequencer #(.ADDR_W(4), .DATA_W(16), .HOLD_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .loop_en     (loop_en),
      .first_addr  (first_addr),
      .last_addr   (last_addr),
      .hold_cycles (hold_cycles),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .busy        (busy),
      .done        (done)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ROM model: one-cycle registered read
   always @(posedge clk) rom_data <= rom[rom_addr];

   // Cycle counter for handshake spacing
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: a handshake happens at the next rising edge
   always @(negedge clk) begin
      if (rst_n && data_valid && data_ready) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected observed=%h expected=none", data_out);
         end
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            assert (data_out === e.d) else begin
               errors++;
               $error("FAIL sb_data observed=%h expected=%h", data_out, e.d);
            end
            checks++;
            assert (rom_addr === e.a) else begin
               errors++;
               $error("FAIL sb_addr observed=%h expected=%h", rom_addr, e.a);
            end
         end
         acc_times.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] a);
      exp_t e;
      e.a = a;
      e.d = rom[a];
      sb.push_back(e);
   endtask

   task automatic run_start(input logic [3:0] f, input logic [3:0] l,
                            input logic [7:0] h, input logic lp);
      first_addr  = f;
      last_addr   = l;
      hold_cycles = h;
      loop_en     = lp;
      start       = 1'b1;
      tick(1);
      start       = 1'b0;
   endtask

   // Run until the sequencer returns to IDLE; expect exactly one done pulse
   task automatic finish_seq(input string tag);
      int pulses;
      pulses = 0;
      for (int i = 0; i < 80; i++) begin
         tick(1);
         if (done) pulses++;
         if (!busy) break;
      end
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      chk({tag, "_done_pulses"}, 32'(pulses), 32'd1);
      tick(1);
      chk({tag, "_done_low"}, 32'(done), 32'd0);
   endtask

   task automatic chk_gaps(input string tag, input int n, input int gap);
      chk({tag, "_accepts"}, 32'(acc_times.size()), 32'(n));
      for (int i = 1; i < acc_times.size(); i++)
         chk({tag, "_gap"}, 32'(acc_times[i] - acc_times[i-1]), 32'(gap));
   endtask

   initial begin
      errors = 0;
      checks = 0;
      cyc = 0;
      rom[0] = 16'h5601; rom[1] = 16'h3401; rom[2] = 16'h1801; rom[3] = 16'h0ac1;
      for (int i = 4; i < 14; i++) rom[i] = 16'h1000 + 16'(i);
      rom[14] = 16'h5601; rom[15] = 16'h5401;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
      first_addr = '0; last_addr = '0; hold_cycles = '0; data_ready = 1'b0;

      // Reset state
      tick(3);
      chk("rst_addr",  32'(rom_addr),   32'd0);
      chk("rst_data",  32'(data_out),   32'd0);
      chk("rst_valid", 32'(data_valid), 32'd0);
      chk("rst_busy",  32'(busy),       32'd0);
      chk("rst_done",  32'(done),       32'd0);
      rst_n = 1'b1;
      tick(2);

      // 1: basic range 0..3, ready always high
      data_ready = 1'b1;
      acc_times.delete();
      for (int a = 0; a < 4; a++) push(4'(a));
      run_start(4'd0, 4'd3, 8'd0, 1'b0);
      chk("t1_busy_e0",  32'(busy),       32'd1);
      chk("t1_addr_e0",  32'(rom_addr),   32'd0);
      chk("t1_valid_e0", 32'(data_valid), 32'd0);
      tick(1);
      chk("t1_valid_e1", 32'(data_valid), 32'd0);
      tick(1);
      chk("t1_valid_e2", 32'(data_valid), 32'd1);
      chk("t1_data_e2",  32'(data_out),   32'h5601);
      finish_seq("t1");
      chk_gaps("t1", 4, 3);
      chk("t1_sb_empty", 32'(sb.size()), 32'd0);

      // 2: backpressure on word 2
      acc_times.delete();
      for (int a = 0; a < 4; a++) push(4'(a));
      run_start(4'd0, 4'd3, 8'd0, 1'b0);
      tick(3);
      data_ready = 1'b0;
      tick(2);
      for (int i = 0; i < 5; i++) begin
         chk("t2_stall_data",  32'(data_out),   32'h3401);
         chk("t2_stall_valid", 32'(data_valid), 32'd1);
         chk("t2_stall_addr",  32'(rom_addr),   32'd1);
         if (i < 4) tick(1);
      end
      data_ready = 1'b1;
      finish_seq("t2");
      chk("t2_accepts", 32'(acc_times.size()), 32'd4);
      chk("t2_sb_empty", 32'(sb.size()), 32'd0);

      // 3: wrap-around range 14..1; config changes while busy are ignored
      acc_times.delete();
      push(4'd14); push(4'd15); push(4'd0); push(4'd1);
      run_start(4'd14, 4'd1, 8'd0, 1'b0);
      first_addr = 4'd7; last_addr = 4'd9; loop_en = 1'b1; hold_cycles = 8'd2;
      finish_seq("t3");
      chk_gaps("t3", 4, 3);
      chk("t3_sb_empty", 32'(sb.size()), 32'd0);

      // 4: loop 2..3 with hold=4, then stop mid-HOLD
      acc_times.delete();
      push(4'd2); push(4'd3); push(4'd2); push(4'd3);
      run_start(4'd2, 4'd3, 8'd4, 1'b1);
      for (int i = 0; i < 60 && acc_times.size() < 4; i++) tick(1);
      chk_gaps("t4", 4, 7);
      tick(1);
      chk("t4_in_hold", 32'(busy), 32'd1);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      chk("t4_stop_busy",  32'(busy),       32'd0);
      chk("t4_stop_valid", 32'(data_valid), 32'd0);
      chk("t4_stop_done",  32'(done),       32'd0);
      chk("t4_stop_addr",  32'(rom_addr),   32'd3);
      chk("t4_stop_data",  32'(data_out),   32'h0ac1);
      tick(1);
      chk("t4_no_done", 32'(done), 32'd0);
      chk("t4_sb_empty", 32'(sb.size()), 32'd0);

      // 5: start while busy ignored, async reset in PRESENT, start+stop in IDLE
      data_ready = 1'b0;
      first_addr = 4'd0; last_addr = 4'd3; hold_cycles = 8'd0; loop_en = 1'b0;
      start = 1'b1;
      tick(3);
      chk("t5_valid", 32'(data_valid), 32'd1);
      chk("t5_data",  32'(data_out),   32'h5601);
      first_addr = 4'd9;
      tick(2);
      chk("t5_busy_start_addr", 32'(rom_addr), 32'd0);
      chk("t5_busy_start_data", 32'(data_out), 32'h5601);
      start = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_addr",  32'(rom_addr),   32'd0);
      chk("t5_rst_data",  32'(data_out),   32'd0);
      chk("t5_rst_valid", 32'(data_valid), 32'd0);
      chk("t5_rst_busy",  32'(busy),       32'd0);
      chk("t5_rst_done",  32'(done),       32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      first_addr = 4'd5;
      start = 1'b1;
      stop  = 1'b1;
      tick(1);
      start = 1'b0;
      stop  = 1'b0;
      chk("t5_ss_busy", 32'(busy),     32'd0);
      chk("t5_ss_addr", 32'(rom_addr), 32'd0);
      tick(2);
      chk("t5_ss_busy2",  32'(busy),       32'd0);
      chk("t5_ss_valid2", 32'(data_valid), 32'd0);
      chk("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
